addsub_arbiter: RTL and testbench
=================================

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 Parameter: NUM_REQ, 4, number of requesters (fixed at 4 for this release; port widths derive from it).
REQ-002 Parameter: DW, 8, operand/result width (fixed at 8 to match the adder slice).
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 req_valid_i  input  NUM_REQ  requester k presents an operation.
REQ-006 req_a_i  input  NUM_REQ*DW  operand A; requester k at bits [8k+7:8k].
REQ-007 req_b_i  input  NUM_REQ*DW  operand B; same packing.
REQ-008 req_op_i  input  NUM_REQ  0 = add, 1 = subtract (A-B).
REQ-009 req_ready_o  output  NUM_REQ  one-hot grant; transfer when valid & ready.
REQ-010 rsp_valid_o  output  1  response register holds a result.
REQ-011 rsp_ready_i  input  1  consumer accepts the response.
REQ-012 rsp_id_o  output  2  index of requester that produced the response.
REQ-013 rsp_result_o  output  DW  8-bit sum/difference, modulo 256.
REQ-014 rsp_carry_o / rsp_ovf_o  output  1 each  carry-out (no-borrow on subtract) and signed overflow.

Function
REQ-015 State machine: EMPTY (no response held) and FULL (rsp_valid_o=1).
REQ-016 Accept condition: accept = (state==EMPTY) | (rsp_ready_i & rsp_valid_o); at most one grant per cycle.
REQ-017 req_ready_o SHALL be combinational: when accept and any req_valid_i set, exactly the round-robin winner bit is 1; otherwise all zero.
REQ-018 req_ready_o SHALL NOT depend on req_a_i/req_b_i/req_op_i.
REQ-019 Round-robin: search starts at priority pointer ptr, wraps 3->0; after a transfer by requester k, ptr = (k+1) mod 4; ptr unchanged when no transfer.
REQ-020 Winner's operands and op drive the adder combinationally; result, carry, ovf, id registered on the transfer edge (latency 1 cycle, rsp_valid_o high the cycle after the transfer).
REQ-021 Subtract = A + ~B + 1; carry = bit-8 of that sum; ovf = carry into bit 7 XOR carry out of bit 7.
REQ-022 Transitions: EMPTY->FULL on transfer; FULL->EMPTY on rsp_ready_i with no transfer; FULL->FULL on simultaneous drain and transfer (back-to-back, full throughput one op/cycle).
REQ-023 While FULL and rsp_ready_i=0, all rsp_* outputs SHALL hold stable and req_ready_o SHALL be zero.
REQ-024 Requester deasserting valid before grant is legal; no state change results.
REQ-025 rsp_ready_i while EMPTY is ignored.

Reset
REQ-026 On rst_ni low (asynchronous, any cycle, including mid-transfer): state=EMPTY, ptr=0, rsp_valid_o=0, rsp_id_o=0, rsp_result_o=0, rsp_carry_o=0, rsp_ovf_o=0; req_ready_o=0 while reset asserted.
REQ-027 Any in-flight response is discarded by reset; first grant after release follows ptr=0.

Structure
REQ-028 Shared package holds NUM_REQ, DW, the state enum (EMPTY, FULL) and the response struct (id, result, carry, ovf).
REQ-029 One sub-module: the team's combinational 8-bit adder/subtractor add_subtract (a_i, b_i, add_sub, result_o, o_carry, o_ovf), instantiated once and muxed between requesters.
REQ-030 Round-robin selection implemented as a function/block inside addsub_arbiter, not a separate module.

Verification
REQ-031 Single add: req 0 valid, A=0x7F, B=0x01, op=0 -> ready[0] same cycle; next cycle rsp_valid=1, id=0, result=0x80, carry=0, ovf=1.
REQ-032 Subtract: req 2, A=0x05, B=0x07, op=1 -> result=0xFE, carry=0, ovf=0, id=2; A=0x80,B=0x01,op=1 -> result=0x7F, carry=1, ovf=1.
REQ-033 Fairness: all four valid continuously, rsp_ready_i=1 -> grants 0,1,2,3,0,... one per cycle, rsp_valid stays high, ids follow same order.
REQ-034 Backpressure: rsp_ready_i=0 for 5 cycles with response held -> rsp_* stable, req_ready_o=0 throughout; on release, drain and next grant occur in the same cycle.
REQ-035 Wrap: ptr=3 (after grant to 2), only req 1 and 3 valid -> grant 3 then 1.
REQ-036 Reset mid-operation: assert rst_ni low while FULL -> rsp_valid_o=0 immediately (asynchronous), all outputs zero; after release with req 1 and 0 valid, req 0 is granted first.

Source files
------------

// File: rtl/addsub_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : addsub_arbiter_pkg
// Brief   : Shared sizes, FSM state encoding and response record for the
//           round-robin add/subtract arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package addsub_arbiter_pkg;

  localparam int NUM_REQ = 4;              // number of requesters
  localparam int DW      = 8;              // operand / result width
  localparam int IDW     = $clog2(NUM_REQ); // requester index width

  // Legacy-compatible state encodings, reused as the enum values below.
  localparam logic [0:0] C_ST_EMPTY = 1'b0;
  localparam logic [0:0] C_ST_FULL  = 1'b1;

  typedef enum logic [0:0] {
    EMPTY = C_ST_EMPTY,  // no response held
    FULL  = C_ST_FULL    // response register valid
  } state_e;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [DW-1:0]  result;
    logic           carry;
    logic           ovf;
  } rsp_t;

endpackage : addsub_arbiter_pkg
`default_nettype wire

// File: rtl/addsub_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : addsub_arbiter_if
// Brief   : Request/response bundle between requesters, arbiter and consumer.
//           slave = arbiter side, master = requester/consumer side.
// Revision: 1.0 - initial release
// ============================================================================
interface addsub_arbiter_if
  import addsub_arbiter_pkg::*;
();

  logic [NUM_REQ-1:0]    req_valid_i;
  logic [NUM_REQ*DW-1:0] req_a_i;
  logic [NUM_REQ*DW-1:0] req_b_i;
  logic [NUM_REQ-1:0]    req_op_i;
  logic [NUM_REQ-1:0]    req_ready_o;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [IDW-1:0]        rsp_id_o;
  logic [DW-1:0]         rsp_result_o;
  logic                  rsp_carry_o;
  logic                  rsp_ovf_o;

  modport slave (
    input  req_valid_i, req_a_i, req_b_i, req_op_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_id_o, rsp_result_o,
           rsp_carry_o, rsp_ovf_o
  );

  modport master (
    output req_valid_i, req_a_i, req_b_i, req_op_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_result_o,
           rsp_carry_o, rsp_ovf_o
  );

endinterface : addsub_arbiter_if
`default_nettype wire

// File: rtl/addsub_arbiter_add_subtract.sv
`default_nettype none
// ============================================================================
// Module  : add_subtract
// Brief   : Combinational 8-bit adder/subtractor. Subtract is A + ~B + 1, so
//           carry-out means "no borrow". Overflow is the carry into the sign
//           bit XOR the carry out of it.
// Revision: 1.0 - initial release
// ============================================================================
module add_subtract
  import addsub_arbiter_pkg::*;
(
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic          add_sub,   // 0 = add, 1 = subtract
  output logic [DW-1:0] result_o,
  output logic          o_carry,
  output logic          o_ovf
);

  logic [DW-1:0] b_eff;
  logic [DW:0]   sum_full;   // full-width sum, MSB is carry-out
  logic [DW-1:0] sum_low;    // sum of the bits below the sign bit, MSB is carry into sign

  // Invert B and inject the +1 through the carry-in when subtracting.
  always_comb begin
    b_eff    = b_i ^ {DW{add_sub}};
    sum_full = {1'b0, a_i} + {1'b0, b_eff} + {{DW{1'b0}}, add_sub};
    sum_low  = {1'b0, a_i[DW-2:0]} + {1'b0, b_eff[DW-2:0]} + {{(DW-1){1'b0}}, add_sub};
    result_o = sum_full[DW-1:0];
    o_carry  = sum_full[DW];
    o_ovf    = sum_low[DW-1] ^ sum_full[DW];
  end

endmodule : add_subtract
`default_nettype wire

// File: rtl/addsub_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : addsub_arbiter
// Brief   : Round-robin arbiter in front of a single shared add/subtract
//           unit with a one-entry response register. Grants are combinational,
//           results appear one cycle after the transfer, and a simultaneous
//           drain + grant sustains one operation per cycle.
// Revision: 1.0 - initial release
// ============================================================================
module addsub_arbiter
  import addsub_arbiter_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  addsub_arbiter_if.slave  bus
);

  // Round-robin pick: first valid requester at or after ptr, wrapping.
  // Returns {found, index}. Scanning from the farthest offset down lets the
  // nearest valid requester overwrite the result last.
  function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                           input logic [IDW-1:0]     ptr);
    logic [IDW:0]   pick;
    logic [IDW-1:0] idx;
    logic [IDW-1:0] off;
    pick = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      off = i[IDW-1:0];
      idx = ptr + off;
      if (valid[idx]) pick = {1'b1, idx};
    end
    return pick;
  endfunction

  state_e             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  rsp_t               rsp_q, rsp_d;

  logic [IDW:0]       pick;
  logic [IDW-1:0]     win_id;
  logic               rsp_valid;
  logic               accept;
  logic               grant;
  logic [NUM_REQ-1:0] req_ready;

  logic [DW-1:0]      add_a;
  logic [DW-1:0]      add_b;
  logic               add_op;
  logic [DW-1:0]      add_res;
  logic               add_carry;
  logic               add_ovf;

  // Arbitration: grant only depends on valids, pointer and response state.
  // Reset gates the grant so nothing is offered while rst_ni is low.
  always_comb begin
    rsp_valid = (state_q == FULL);
    accept    = (state_q == EMPTY) | (bus.rsp_ready_i & rsp_valid);
    pick      = rr_pick(bus.req_valid_i, ptr_q);
    win_id    = pick[IDW-1:0];
    grant     = rst_ni & accept & pick[IDW];
    req_ready = grant ? (NUM_REQ'(1) << win_id) : '0;
  end

  // Steer the winner's operands into the shared adder.
  always_comb begin
    add_a  = bus.req_a_i[win_id*DW +: DW];
    add_b  = bus.req_b_i[win_id*DW +: DW];
    add_op = bus.req_op_i[win_id];
  end

  add_subtract u_add_subtract (
    .a_i      (add_a),
    .b_i      (add_b),
    .add_sub  (add_op),
    .result_o (add_res),
    .o_carry  (add_carry),
    .o_ovf    (add_ovf)
  );

  // Next state: a transfer (re)fills the response register and advances the
  // pointer past the winner; a drain without transfer empties it.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rsp_d   = rsp_q;
    if (grant) begin
      state_d      = FULL;
      ptr_d        = win_id + 1'b1;
      rsp_d.id     = win_id;
      rsp_d.result = add_res;
      rsp_d.carry  = add_carry;
      rsp_d.ovf    = add_ovf;
    end else if (rsp_valid && bus.rsp_ready_i) begin
      state_d = EMPTY;
    end
  end

  // State, pointer and response registers with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rsp_q   <= rsp_d;
    end
  end

  assign bus.req_ready_o  = req_ready;
  assign bus.rsp_valid_o  = rsp_valid;
  assign bus.rsp_id_o     = rsp_q.id;
  assign bus.rsp_result_o = rsp_q.result;
  assign bus.rsp_carry_o  = rsp_q.carry;
  assign bus.rsp_ovf_o    = rsp_q.ovf;

endmodule : addsub_arbiter
`default_nettype wire

// File: tb/tb_addsub_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_addsub_arbiter
// Brief   : Directed self-checking bench for addsub_arbiter. Inputs change on
//           the falling edge; combinational grants are checked 1 ns later and
//           registered responses 1 ns after the rising edge.
// Revision: 1.0 - initial release
// ============================================================================
module tb_addsub_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  addsub_arbiter_if bus ();

  addsub_arbiter dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int k, input logic [7:0] a, input logic [7:0] b, input logic op);
    bus.req_a_i[8*k +: 8] = a;
    bus.req_b_i[8*k +: 8] = b;
    bus.req_op_i[k]       = op;
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic [1:0] id,
                         input logic [7:0] res, input logic c, input logic o);
    chk({tag, "_valid"},  32'(bus.rsp_valid_o),  32'(v));
    chk({tag, "_id"},     32'(bus.rsp_id_o),     32'(id));
    chk({tag, "_result"}, 32'(bus.rsp_result_o), 32'(res));
    chk({tag, "_carry"},  32'(bus.rsp_carry_o),  32'(c));
    chk({tag, "_ovf"},    32'(bus.rsp_ovf_o),    32'(o));
  endtask

  // Hand-computed per-requester results for the fairness phase.
  logic [7:0] fair_res [4];
  logic       fair_cy  [4];

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.req_valid_i = 4'hF;   // valids present during reset must not be granted
    bus.req_a_i     = '0;
    bus.req_b_i     = '0;
    bus.req_op_i    = '0;
    bus.rsp_ready_i = 1'b0;

    fair_res[0] = 8'h02; fair_cy[0] = 1'b0;  // 01+01
    fair_res[1] = 8'h30; fair_cy[1] = 1'b0;  // 10+20
    fair_res[2] = 8'hFE; fair_cy[2] = 1'b0;  // 05-07
    fair_res[3] = 8'h00; fair_cy[3] = 1'b1;  // FF+01

    // ---- reset state
    #12;
    chk("rst_ready", 32'(bus.req_ready_o), 32'h0);
    chk_rsp("rst", 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    bus.req_valid_i = 4'h0;
    rst_n = 1'b1;

    // ---- single add on requester 0: 7F+01
    @(negedge clk);
    bus.rsp_ready_i = 1'b1;
    bus.req_valid_i = 4'b0001;
    set_op(0, 8'h7F, 8'h01, 1'b0);
    #1 chk("add_ready", 32'(bus.req_ready_o), 32'h1);
    @(posedge clk); #1;
    chk_rsp("add", 1'b1, 2'd0, 8'h80, 1'b0, 1'b1);

    // ---- subtract on requester 2: 05-07 (ptr=1, so 2 wins), back-to-back drain
    @(negedge clk);
    bus.req_valid_i = 4'b0100;
    set_op(2, 8'h05, 8'h07, 1'b1);
    #1 chk("sub1_ready", 32'(bus.req_ready_o), 32'h4);
    @(posedge clk); #1;
    chk_rsp("sub1", 1'b1, 2'd2, 8'hFE, 1'b0, 1'b0);

    // ---- subtract 80-01 on requester 2 (ptr=3 wraps to 2)
    @(negedge clk);
    set_op(2, 8'h80, 8'h01, 1'b1);
    #1 chk("sub2_ready", 32'(bus.req_ready_o), 32'h4);
    @(posedge clk); #1;
    chk_rsp("sub2", 1'b1, 2'd2, 8'h7F, 1'b1, 1'b1);

    // ---- wrap: ptr=3, requesters 1 and 3 valid -> 3 then 1
    @(negedge clk);
    bus.req_valid_i = 4'b1010;
    set_op(1, 8'h10, 8'h20, 1'b0);
    set_op(3, 8'hFF, 8'h01, 1'b0);
    #1 chk("wrap3_ready", 32'(bus.req_ready_o), 32'h8);
    @(posedge clk); #1;
    chk_rsp("wrap3", 1'b1, 2'd3, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    #1 chk("wrap1_ready", 32'(bus.req_ready_o), 32'h2);
    @(posedge clk); #1;
    chk_rsp("wrap1", 1'b1, 2'd1, 8'h30, 1'b0, 1'b0);

    // ---- fairness: all valid, ptr=2 -> 2,3,0,1,2
    @(negedge clk);
    bus.req_valid_i = 4'hF;
    set_op(0, 8'h01, 8'h01, 1'b0);
    set_op(2, 8'h05, 8'h07, 1'b1);
    for (int i = 0; i < 5; i++) begin
      automatic int w = (2 + i) % 4;
      if (i != 0) @(negedge clk);
      #1 chk($sformatf("fair%0d_ready", i), 32'(bus.req_ready_o), 32'(1 << w));
      @(posedge clk); #1;
      chk($sformatf("fair%0d_valid", i),  32'(bus.rsp_valid_o),  32'h1);
      chk($sformatf("fair%0d_id", i),     32'(bus.rsp_id_o),     32'(w));
      chk($sformatf("fair%0d_result", i), 32'(bus.rsp_result_o), 32'(fair_res[w]));
      chk($sformatf("fair%0d_carry", i),  32'(bus.rsp_carry_o),  32'(fair_cy[w]));
    end

    // ---- backpressure: hold id 2 / FE for 5 cycles, no grants
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      #1 chk($sformatf("bp%0d_ready", i), 32'(bus.req_ready_o), 32'h0);
      @(posedge clk); #1;
      chk_rsp($sformatf("bp%0d", i), 1'b1, 2'd2, 8'hFE, 1'b0, 1'b0);
    end
    // release: drain and grant to 3 (ptr=3) in the same cycle
    @(negedge clk);
    bus.rsp_ready_i = 1'b1;
    #1 chk("bprel_ready", 32'(bus.req_ready_o), 32'h8);
    @(posedge clk); #1;
    chk_rsp("bprel", 1'b1, 2'd3, 8'h00, 1'b1, 1'b0);

    // ---- drain to EMPTY, then rsp_ready while EMPTY is ignored
    @(negedge clk);
    bus.req_valid_i = 4'h0;
    #1 chk("drain_ready", 32'(bus.req_ready_o), 32'h0);
    @(posedge clk); #1;
    chk("drain_valid", 32'(bus.rsp_valid_o), 32'h0);
    @(posedge clk); #1;
    chk("empty_valid", 32'(bus.rsp_valid_o), 32'h0);

    // ---- reset mid-operation: fill with requester 0 (ptr=0), then reset
    @(negedge clk);
    bus.req_valid_i = 4'b0001;
    #1 chk("pre_rst_ready", 32'(bus.req_ready_o), 32'h1);
    @(posedge clk); #1;
    chk_rsp("pre_rst", 1'b1, 2'd0, 8'h02, 1'b0, 1'b0);
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    bus.req_valid_i = 4'b0011;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(bus.req_ready_o), 32'h0);
    chk_rsp("midrst", 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("postrst_ready", 32'(bus.req_ready_o), 32'h1);
    @(posedge clk); #1;
    chk_rsp("postrst", 1'b1, 2'd0, 8'h02, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_addsub_arbiter
`default_nettype wire
